// File: rtl/retire_commit_wide_if.sv
// Bundle between the ROB commit window and the retire stage, plus the retire
// stage's commit/free, store, BTB, redirect and status outputs.
interface retire_commit_wide_if #(
  parameter int RETIRE_WIDTH = 2,
  parameter int ROB_WIDTH    = 5,
  parameter int PHY_WIDTH    = 6,
  parameter int ADDR_WIDTH   = 32,
  parameter int SID_WIDTH    = 4
);
  localparam int W  = RETIRE_WIDTH;
  localparam int CW = $clog2(RETIRE_WIDTH + 1);

  logic                    flush;
  logic [ROB_WIDTH-1:0]    rob_head;
  logic [ROB_WIDTH:0]      rob_count;
  logic [W-1:0]            win_finish;
  logic [7*W-1:0]          win_opcode;
  logic [5*W-1:0]          win_rd_arch;
  logic [PHY_WIDTH*W-1:0]  win_rd_phy_old;
  logic [PHY_WIDTH*W-1:0]  win_rd_phy_new;
  logic [SID_WIDTH*W-1:0]  win_store_id;
  logic [W-1:0]            win_mispredict;
  logic [W-1:0]            win_taken;
  logic [ADDR_WIDTH*W-1:0] win_target;
  logic [ADDR_WIDTH*W-1:0] win_pc;

  logic [CW-1:0]           retire_count;
  logic [W-1:0]            pr_valid;
  logic [5*W-1:0]          pr_rd_arch;
  logic [PHY_WIDTH*W-1:0]  pr_phy_old;
  logic [PHY_WIDTH*W-1:0]  pr_phy_new;
  logic                    store_valid;
  logic [SID_WIDTH-1:0]    store_id;
  logic                    btb_valid;
  logic [ADDR_WIDTH-1:0]   btb_pc;
  logic [ADDR_WIDTH-1:0]   btb_target;
  logic                    btb_taken;
  logic                    isFlush;
  logic [ADDR_WIDTH-1:0]   targetPC;
  logic                    done_valid;
  logic [63:0]             instret;

  modport master (
    output flush, rob_head, rob_count, win_finish, win_opcode, win_rd_arch,
           win_rd_phy_old, win_rd_phy_new, win_store_id, win_mispredict,
           win_taken, win_target, win_pc,
    input  retire_count, pr_valid, pr_rd_arch, pr_phy_old, pr_phy_new,
           store_valid, store_id, btb_valid, btb_pc, btb_target, btb_taken,
           isFlush, targetPC, done_valid, instret
  );

  modport slave (
    input  flush, rob_head, rob_count, win_finish, win_opcode, win_rd_arch,
           win_rd_phy_old, win_rd_phy_new, win_store_id, win_mispredict,
           win_taken, win_target, win_pc,
    output retire_count, pr_valid, pr_rd_arch, pr_phy_old, pr_phy_new,
           store_valid, store_id, btb_valid, btb_pc, btb_target, btb_taken,
           isFlush, targetPC, done_valid, instret
  );
endinterface

// File: rtl/retire_commit_wide.sv
// In-order multi-lane commit: pops finished ROB head entries, truncating the
// group at the first store, control-flow op, mispredict or SYSTEM.
module retire_commit_wide #(
  parameter int RETIRE_WIDTH  = 2,
  parameter int NUM_ROB_ENTRY = 32,
  parameter int ROB_WIDTH     = 5,
  parameter int PHY_WIDTH     = 6,
  parameter int ADDR_WIDTH    = 32,
  parameter int SID_WIDTH     = 4
) (
  input logic                  clk,
  input logic                  rst,
  retire_commit_wide_if.slave  bus
);
  localparam int W  = RETIRE_WIDTH;
  localparam int CW = $clog2(RETIRE_WIDTH + 1);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_e;

  function automatic logic writes_rd(input logic [6:0] op);
    return (op == OP_REG) || (op == OP_IMM) || (op == OP_LUI) || (op == OP_AUIPC) ||
           (op == OP_LOAD) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

  function automatic logic is_cf(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

  state_e                  state_q, state_d;
  logic [W-1:0]            pr_valid_q;
  logic [5*W-1:0]          pr_rd_arch_q;
  logic [PHY_WIDTH*W-1:0]  pr_phy_old_q, pr_phy_new_q;
  logic                    store_valid_q, btb_valid_q, btb_taken_q;
  logic [SID_WIDTH-1:0]    store_id_q;
  logic [ADDR_WIDTH-1:0]   btb_pc_q, btb_target_q, targetpc_q;
  logic [63:0]             instret_q;

  logic [W-1:0]            prv;
  logic [CW-1:0]           cnt;
  logic                    open, st_hit, br_hit, br_tk, sys_hit, misp_hit;
  logic [SID_WIDTH-1:0]    st_id;
  logic [ADDR_WIDTH-1:0]   br_pc, br_tgt, misp_tgt;
  logic [6:0]              op;

  wire [ROB_WIDTH-1:0] unused_dbg = bus.rob_head ^ ROB_WIDTH'(NUM_ROB_ENTRY - 1);

  // Lane scan: each lane retires only if every older lane retired and did not close the group.
  always_comb begin
    prv      = '0;
    cnt      = '0;
    st_hit   = 1'b0;
    br_hit   = 1'b0;
    br_tk    = 1'b0;
    sys_hit  = 1'b0;
    misp_hit = 1'b0;
    st_id    = '0;
    br_pc    = '0;
    br_tgt   = '0;
    misp_tgt = '0;
    op       = '0;
    open     = (state_q == S_RUN) && !bus.flush && !rst;
    for (int i = 0; i < W; i++) begin
      op = bus.win_opcode[i*7 +: 7];
      if (open && ((ROB_WIDTH+1)'(i) < bus.rob_count) && bus.win_finish[i]) begin
        cnt    = cnt + CW'(1);
        prv[i] = writes_rd(op) && (bus.win_rd_arch[i*5 +: 5] != 5'd0);
        if (op == OP_STORE) begin
          st_hit = 1'b1;
          st_id  = bus.win_store_id[i*SID_WIDTH +: SID_WIDTH];
        end
        if (is_cf(op)) begin
          br_hit = 1'b1;
          br_pc  = bus.win_pc[i*ADDR_WIDTH +: ADDR_WIDTH];
          br_tgt = bus.win_target[i*ADDR_WIDTH +: ADDR_WIDTH];
          br_tk  = bus.win_taken[i];
        end
        if (op == OP_SYSTEM) sys_hit = 1'b1;
        if (bus.win_mispredict[i]) begin
          misp_hit = 1'b1;
          misp_tgt = bus.win_target[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
        if ((op == OP_STORE) || is_cf(op) || (op == OP_SYSTEM) || bus.win_mispredict[i])
          open = 1'b0;
      end else begin
        open = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN: begin
        if (sys_hit)       state_d = S_HALT;
        else if (misp_hit) state_d = S_FLUSH;
      end
      S_FLUSH: state_d = S_RUN;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RUN;
    endcase
    if (bus.flush && (state_q != S_HALT)) state_d = S_RUN;
  end

  // Commit register stage: every side effect appears one cycle after its pop edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_RUN;
      pr_valid_q    <= '0;
      pr_rd_arch_q  <= '0;
      pr_phy_old_q  <= '0;
      pr_phy_new_q  <= '0;
      store_valid_q <= 1'b0;
      store_id_q    <= '0;
      btb_valid_q   <= 1'b0;
      btb_pc_q      <= '0;
      btb_target_q  <= '0;
      btb_taken_q   <= 1'b0;
      targetpc_q    <= '0;
      instret_q     <= '0;
    end else begin
      state_q       <= state_d;
      pr_valid_q    <= prv;
      pr_rd_arch_q  <= bus.win_rd_arch;
      pr_phy_old_q  <= bus.win_rd_phy_old;
      pr_phy_new_q  <= bus.win_rd_phy_new;
      store_valid_q <= st_hit;
      store_id_q    <= st_id;
      btb_valid_q   <= br_hit;
      btb_pc_q      <= br_pc;
      btb_target_q  <= br_tgt;
      btb_taken_q   <= br_tk;
      if (misp_hit && !sys_hit) targetpc_q <= misp_tgt;
      instret_q     <= instret_q + 64'(cnt);
    end
  end

  assign bus.retire_count = cnt;
  assign bus.pr_valid     = pr_valid_q;
  assign bus.pr_rd_arch   = pr_rd_arch_q;
  assign bus.pr_phy_old   = pr_phy_old_q;
  assign bus.pr_phy_new   = pr_phy_new_q;
  assign bus.store_valid  = store_valid_q;
  assign bus.store_id     = store_id_q;
  assign bus.btb_valid    = btb_valid_q;
  assign bus.btb_pc       = btb_pc_q;
  assign bus.btb_target   = btb_target_q;
  assign bus.btb_taken    = btb_taken_q;
  assign bus.isFlush      = (state_q == S_FLUSH);
  assign bus.targetPC     = targetpc_q;
  assign bus.done_valid   = (state_q == S_HALT);
  assign bus.instret      = instret_q;
endmodule

// File: tb/tb_retire_commit_wide.sv
// Bench for retire_commit_wide: a queue-based ROB model feeds the commit window and
// predicts each cycle's pop count and next-cycle commit outputs for a scoreboard.
module tb_retire_commit_wide;
  localparam int W  = 2;
  localparam int RW = 5;
  localparam int PW = 6;
  localparam int AW = 32;
  localparam int SW = 4;

  localparam logic [6:0] ADDI = 7'b0010011, ADD = 7'b0110011, LUI = 7'b0110111;
  localparam logic [6:0] LW = 7'b0000011, SWOP = 7'b0100011, BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, ECALL = 7'b1110011;
  localparam logic [6:0] CUST = 7'b0001011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  retire_commit_wide_if #(.RETIRE_WIDTH(W), .ROB_WIDTH(RW), .PHY_WIDTH(PW),
                          .ADDR_WIDTH(AW), .SID_WIDTH(SW)) bus ();

  retire_commit_wide #(.RETIRE_WIDTH(W), .NUM_ROB_ENTRY(32), .ROB_WIDTH(RW),
                       .PHY_WIDTH(PW), .ADDR_WIDTH(AW), .SID_WIDTH(SW))
    dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [6:0]    op;
    logic [4:0]    rd;
    logic [PW-1:0] po, pn;
    logic [SW-1:0] sid;
    bit            misp, tk;
    logic [AW-1:0] tgt, pc;
  } ent_t;

  typedef struct {
    int            due;
    logic [W-1:0]  prv;
    logic [4:0]    ra [W];
    logic [PW-1:0] po [W];
    logic [PW-1:0] pn [W];
    bit            stv;
    logic [SW-1:0] sid;
    bit            btbv, btk;
    logic [AW-1:0] bpc, btgt, tpc;
    bit            isf, done;
    logic [63:0]   ir;
  } exp_t;

  ent_t rob[$];
  exp_t regq[$];
  int   rcq[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  bit            m_halt = 0, m_fl = 0;
  logic [AW-1:0] m_tpc = '0;
  logic [63:0]   m_ir = '0;

  function automatic bit is_cf(input logic [6:0] op);
    return (op == BEQ) || (op == JAL) || (op == JALR);
  endfunction

  function automatic bit wr_rd(input logic [6:0] op);
    return (op == ADDI) || (op == ADD) || (op == LUI) || (op == LW) || (op == JAL) || (op == JALR);
  endfunction

  function automatic ent_t mk(input logic [6:0] op, input logic [4:0] rd,
                              input bit misp, input logic [AW-1:0] tgt);
    ent_t e;
    e.op = op; e.rd = rd; e.misp = misp; e.tgt = tgt;
    e.po = PW'($urandom); e.pn = PW'($urandom); e.sid = SW'($urandom);
    e.tk = 1'($urandom); e.pc = $urandom;
    return e;
  endfunction

  function automatic ent_t rand_ent(input bit allow_sys);
    logic [6:0] op;
    if (allow_sys && $urandom_range(99) == 0) op = ECALL;
    else begin
      case ($urandom_range(9))
        0, 1: op = ADDI;
        2:    op = ADD;
        3:    op = LUI;
        4:    op = LW;
        5:    op = SWOP;
        6:    op = BEQ;
        7:    op = JAL;
        8:    op = JALR;
        default: op = CUST;
      endcase
    end
    return mk(op, 5'($urandom), is_cf(op) && ($urandom_range(7) == 0), $urandom);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exv);
    total++;
    if (act !== exv) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exv);
    end
  endtask

  // One cycle: drive the window, predict the pop and the registered results, advance.
  task automatic step(input bit r, input bit fl, input int fp);
    ent_t e, last;
    exp_t x;
    int rc;
    logic [W-1:0] fin;
    rst = r;
    bus.flush = fl;
    bus.rob_head = RW'($urandom);
    bus.rob_count = (RW+1)'(rob.size());
    for (int i = 0; i < W; i++) begin
      fin[i] = ($urandom_range(99) < fp);
      e = (i < rob.size()) ? rob[i] : rand_ent(1'b1);
      bus.win_opcode[i*7 +: 7]       = e.op;
      bus.win_rd_arch[i*5 +: 5]      = e.rd;
      bus.win_rd_phy_old[i*PW +: PW] = e.po;
      bus.win_rd_phy_new[i*PW +: PW] = e.pn;
      bus.win_store_id[i*SW +: SW]   = e.sid;
      bus.win_mispredict[i]          = e.misp;
      bus.win_taken[i]               = e.tk;
      bus.win_target[i*AW +: AW]     = e.tgt;
      bus.win_pc[i*AW +: AW]         = e.pc;
    end
    bus.win_finish = fin;

    x.due = cyc + 1; x.prv = '0; x.stv = 0; x.sid = '0; x.btbv = 0; x.btk = 0;
    x.bpc = '0; x.btgt = '0;
    for (int i = 0; i < W; i++) begin x.ra[i] = '0; x.po[i] = '0; x.pn[i] = '0; end
    rc = 0;
    last = mk(ADDI, 5'd0, 1'b0, '0);
    if (!r && !fl && !m_halt && !m_fl) begin
      while (rc < W && rc < rob.size()) begin
        if (!fin[rc]) break;
        e = rob[rc];
        if (wr_rd(e.op) && e.rd != 5'd0) begin
          x.prv[rc] = 1'b1; x.ra[rc] = e.rd; x.po[rc] = e.po; x.pn[rc] = e.pn;
        end
        if (e.op == SWOP) begin x.stv = 1; x.sid = e.sid; end
        if (is_cf(e.op)) begin x.btbv = 1; x.bpc = e.pc; x.btgt = e.tgt; x.btk = e.tk; end
        last = e;
        rc++;
        if (e.op == SWOP || is_cf(e.op) || e.op == ECALL || e.misp) break;
      end
    end
    repeat (rc) void'(rob.pop_front());

    if (r) begin
      m_halt = 0; m_fl = 0; m_ir = '0; m_tpc = '0; rob.delete();
    end else begin
      m_ir = m_ir + 64'(rc);
      if (fl) begin m_fl = 0; rob.delete(); end
      else if (m_fl) m_fl = 0;
      else if (rc > 0 && last.op == ECALL) m_halt = 1;
      else if (rc > 0 && last.misp) begin m_fl = 1; m_tpc = last.tgt; rob.delete(); end
    end
    x.isf = m_fl; x.tpc = m_tpc; x.done = m_halt; x.ir = m_ir;
    rcq.push_back(rc);
    regq.push_back(x);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Monitor: compares the live pop count and whatever registered results are due this cycle.
  initial begin
    exp_t x;
    int erc;
    forever begin
      @(negedge clk);
      if (rcq.size() > 0) begin
        erc = rcq.pop_front();
        chk("retire_count", 64'(bus.retire_count), 64'(erc));
      end
      if (regq.size() > 0 && regq[0].due == cyc) begin
        x = regq.pop_front();
        chk("pr_valid", 64'(bus.pr_valid), 64'(x.prv));
        for (int i = 0; i < W; i++) begin
          if (x.prv[i]) begin
            chk("pr_rd_arch", 64'(bus.pr_rd_arch[i*5 +: 5]), 64'(x.ra[i]));
            chk("pr_phy_old", 64'(bus.pr_phy_old[i*PW +: PW]), 64'(x.po[i]));
            chk("pr_phy_new", 64'(bus.pr_phy_new[i*PW +: PW]), 64'(x.pn[i]));
          end
        end
        chk("store_valid", 64'(bus.store_valid), 64'(x.stv));
        if (x.stv) chk("store_id", 64'(bus.store_id), 64'(x.sid));
        chk("btb_valid", 64'(bus.btb_valid), 64'(x.btbv));
        if (x.btbv) begin
          chk("btb_pc", 64'(bus.btb_pc), 64'(x.bpc));
          chk("btb_target", 64'(bus.btb_target), 64'(x.btgt));
          chk("btb_taken", 64'(bus.btb_taken), 64'(x.btk));
        end
        chk("isFlush", 64'(bus.isFlush), 64'(x.isf));
        if (x.isf) chk("targetPC", 64'(bus.targetPC), 64'(x.tpc));
        chk("done_valid", 64'(bus.done_valid), 64'(x.done));
        chk("instret", bus.instret, x.ir);
      end
    end
  end

  initial begin
    bit r, fl;
    exp_t z;
    bus.flush = 0; bus.rob_head = '0; bus.rob_count = '0; bus.win_finish = '0;
    bus.win_opcode = '0; bus.win_rd_arch = '0; bus.win_rd_phy_old = '0;
    bus.win_rd_phy_new = '0; bus.win_store_id = '0; bus.win_mispredict = '0;
    bus.win_taken = '0; bus.win_target = '0; bus.win_pc = '0;
    z.due = 0; z.prv = '0; z.stv = 0; z.sid = '0; z.btbv = 0; z.btk = 0;
    z.bpc = '0; z.btgt = '0; z.tpc = '0; z.isf = 0; z.done = 0; z.ir = '0;
    for (int i = 0; i < W; i++) begin z.ra[i] = '0; z.po[i] = '0; z.pn[i] = '0; end
    regq.push_back(z);
    @(posedge clk);
    #1;
    step(1, 0, 100);

    for (int k = 1; k <= 4; k++) rob.push_back(mk(ADDI, 5'(k), 0, '0));
    repeat (3) step(0, 0, 100);

    rob.push_back(mk(SWOP, 5'd3, 0, '0));
    rob.push_back(mk(SWOP, 5'd4, 0, '0));
    repeat (3) step(0, 0, 100);

    rob.push_back(mk(BEQ, 5'd0, 1, 32'h100));
    rob.push_back(mk(ADDI, 5'd5, 0, '0));
    repeat (3) step(0, 0, 100);

    rob.push_back(mk(ADDI, 5'd0, 0, '0));
    rob.push_back(mk(JAL, 5'd0, 0, 32'h2000));
    repeat (2) step(0, 0, 100);

    rob.push_back(mk(ADDI, 5'd7, 0, '0));
    rob.push_back(mk(ECALL, 5'd0, 0, '0));
    rob.push_back(mk(ADDI, 5'd8, 0, '0));
    rob.push_back(mk(ADDI, 5'd9, 0, '0));
    repeat (4) step(0, 0, 100);
    step(0, 1, 100);
    step(1, 0, 100);
    step(0, 0, 100);

    rob.push_back(mk(ADDI, 5'd10, 0, '0));
    rob.push_back(mk(ADDI, 5'd11, 0, '0));
    step(0, 1, 100);
    repeat (2) step(0, 0, 100);

    for (int n = 0; n < 3000; n++) begin
      repeat (2) if (rob.size() < 32 && $urandom_range(2) != 0) rob.push_back(rand_ent(1'b1));
      r  = ($urandom_range(299) == 0) || (m_halt && $urandom_range(15) == 0);
      fl = ($urandom_range(39) == 0);
      step(r, fl, 75);
    end

    step(0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(rcq.size() + regq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
